// File: rtl/bcd_stopwatch_core.sv
// Purpose: divides the board clock to a count tick and runs a 00.00-59.99 BCD stopwatch
// Latency: the first count appears DIV clocks after the edge that samples start_stop; all outputs are registered
// Backpressure: none; start_stop and clear are single-cycle pulses acted on at the edge that samples them
module bcd_stopwatch_core #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TICK_HZ    = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap
);

  // Clocks per count; the divider counter is sized to hold DIV-1.
  localparam int DIV = CLOCK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          tick;

  // Next digit values and rollover flag for one count step.
  logic [3:0] nxt0;
  logic [3:0] nxt1;
  logic [3:0] nxt2;
  logic [3:0] nxt3;
  logic       roll;

  // A count step fires at the last clock of each divider interval, only while running.
  assign tick = (state == RUN) && (div_cnt == DIV_LAST);

  // Control FSM; running is registered alongside the state so it tracks RUN exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (clear) begin
      // clear beats start_stop in the same cycle
      state   <= IDLE;
      running <= 1'b0;
    end else if (start_stop) begin
      case (state)
        IDLE: begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: begin
          state   <= PAUSE;
          running <= 1'b0;
        end
        PAUSE: begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Divider advances only in RUN and freezes in PAUSE so a resume finishes the partial interval.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (state == RUN) begin
      if (div_cnt >= DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // BCD carry chain: hundredths and tenths and seconds-ones wrap at 9, seconds-tens wraps at 5.
  // Comparisons use >= so a corrupted digit still falls back into the legal range.
  always_comb begin
    nxt0 = digit0;
    nxt1 = digit1;
    nxt2 = digit2;
    nxt3 = digit3;
    roll = 1'b0;
    if (digit0 >= 4'd9) begin
      nxt0 = 4'd0;
      if (digit1 >= 4'd9) begin
        nxt1 = 4'd0;
        if (digit2 >= 4'd9) begin
          nxt2 = 4'd0;
          if (digit3 >= 4'd5) begin
            nxt3 = 4'd0;
            roll = 1'b1;
          end else begin
            nxt3 = digit3 + 4'd1;
          end
        end else begin
          nxt2 = digit2 + 4'd1;
        end
      end else begin
        nxt1 = digit1 + 4'd1;
      end
    end else begin
      nxt0 = digit0 + 4'd1;
    end
  end

  // Digit registers and the one-cycle wrap pulse, which lands together with the 00.00 display.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      digit0 <= 4'd0;
      digit1 <= 4'd0;
      digit2 <= 4'd0;
      digit3 <= 4'd0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        digit0 <= nxt0;
        digit1 <= nxt1;
        digit2 <= nxt2;
        digit3 <= nxt3;
        wrap   <= roll;
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core with DIV = 10.
// Expectations are queued when a step is launched and checked when that step completes.
module tb_bcd_stopwatch_core;

  logic       clock;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       running;
  logic       wrap;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] dig;
    logic        run;
    logic        wr;
  } exp_t;

  exp_t sb[$];

  bcd_stopwatch_core #(
    .CLOCK_FREQ(1000),
    .TICK_HZ   (100)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .running   (running),
    .wrap      (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_front();
    exp_t        e;
    logic [15:0] obs;
    e   = sb.pop_front();
    obs = {digit3, digit2, digit1, digit0};
    n_assert++;
    assert (obs === e.dig) else begin
      n_fail++;
      $error("FAIL %s digits observed=%h expected=%h", e.tag, obs, e.dig);
    end
    n_assert++;
    assert (running === e.run) else begin
      n_fail++;
      $error("FAIL %s running observed=%b expected=%b", e.tag, running, e.run);
    end
    n_assert++;
    assert (wrap === e.wr) else begin
      n_fail++;
      $error("FAIL %s wrap observed=%b expected=%b", e.tag, wrap, e.wr);
    end
  endtask

  // Queue an expectation, run n clocks, then check it.
  task automatic expect_after(input int n, input string tag, input logic [15:0] dig,
                              input logic run, input logic wr);
    exp_t e;
    e.tag = tag;
    e.dig = dig;
    e.run = run;
    e.wr  = wr;
    sb.push_back(e);
    step(n);
    check_front();
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;

    // Reset for two cycles
    step(2);
    reset = 1'b0;
    expect_after(0, "reset", 16'h0000, 1'b0, 1'b0);

    // Start: running next cycle, first count 11 clocks after the pulse is launched
    start_stop = 1'b1;
    expect_after(1, "start_run", 16'h0000, 1'b1, 1'b0);
    start_stop = 1'b0;
    expect_after(9, "pre_first_tick", 16'h0000, 1'b1, 1'b0);
    expect_after(1, "first_tick", 16'h0001, 1'b1, 1'b0);
    expect_after(10, "second_tick", 16'h0002, 1'b1, 1'b0);

    // Long runs: 100 ticks and 1000 ticks from zero
    expect_after(980, "one_second", 16'h0100, 1'b1, 1'b0);
    expect_after(9000, "ten_seconds", 16'h1000, 1'b1, 1'b0);
    expect_after(30, "at_10_03", 16'h1003, 1'b1, 1'b0);

    // Pause part-way through an interval, hold, then resume the partial interval
    step(5);
    start_stop = 1'b1;
    expect_after(1, "pause", 16'h1003, 1'b0, 1'b0);
    start_stop = 1'b0;
    expect_after(50, "pause_hold", 16'h1003, 1'b0, 1'b0);
    start_stop = 1'b1;
    expect_after(1, "resume", 16'h1003, 1'b1, 1'b0);
    start_stop = 1'b0;
    expect_after(3, "resume_partial", 16'h1003, 1'b1, 1'b0);
    expect_after(1, "resume_tick", 16'h1004, 1'b1, 1'b0);

    // Roll 59.99 -> 00.00 with a single-cycle wrap pulse
    expect_after(49950, "at_59_99", 16'h5999, 1'b1, 1'b0);
    expect_after(10, "wrap", 16'h0000, 1'b1, 1'b1);
    expect_after(1, "wrap_end", 16'h0000, 1'b1, 1'b0);
    expect_after(9, "after_wrap", 16'h0001, 1'b1, 1'b0);

    // clear together with start_stop mid-run
    expect_after(12330, "at_12_34", 16'h1234, 1'b1, 1'b0);
    step(3);
    clear      = 1'b1;
    start_stop = 1'b1;
    expect_after(1, "clear_and_ss", 16'h0000, 1'b0, 1'b0);
    clear      = 1'b0;
    start_stop = 1'b0;
    expect_after(20, "idle_hold", 16'h0000, 1'b0, 1'b0);

    // reset mid-run
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    expect_after(25, "restart", 16'h0002, 1'b1, 1'b0);
    reset = 1'b1;
    expect_after(1, "reset_midrun", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // start_stop coincident with a tick: count applied, then paused
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    expect_after(70, "at_00_07", 16'h0007, 1'b1, 1'b0);
    step(9);
    start_stop = 1'b1;
    expect_after(1, "tick_with_pause", 16'h0008, 1'b0, 1'b0);
    start_stop = 1'b0;
    expect_after(30, "paused_hold", 16'h0008, 1'b0, 1'b0);

    // clear coincident with a tick: clear wins, no wrap
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    expect_after(9, "pre_clear_tick", 16'h0008, 1'b1, 1'b0);
    clear = 1'b1;
    expect_after(1, "clear_on_tick", 16'h0000, 1'b0, 1'b0);
    clear = 1'b0;
    expect_after(15, "cleared_hold", 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
